// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch control states: a request outstanding to memory, an instruction
    // presented to decode, or permanently stopped.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
    localparam logic [15:0] EXC_VECTOR_DEF = 16'h0002;
    localparam logic [15:0] NOP_INST       = 16'h0800;
    localparam logic [15:0] PC_STEP        = 16'h0002;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for an instruction leaving the IF/ID register.
// Priority: execute redirect, RTI, illegal-op, jump, halt, sequential.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        rti_i,
    input  logic [15:0] epc_i,
    input  logic        illegal_i,
    input  logic        jmp_i,
    input  logic [15:0] jmp_disp_i,
    input  logic        halt_i,
    input  logic [15:0] seq_pc_i,
    output logic [15:0] next_pc_o,
    output logic        take_exc_o,
    output logic        halt_o
);

    // Priority mux; only the winning source may raise exception or halt.
    always_comb begin
        next_pc_o  = seq_pc_i;
        take_exc_o = 1'b0;
        halt_o     = 1'b0;
        if (redirect_i) begin
            next_pc_o = redirect_pc_i;
        end else if (rti_i) begin
            next_pc_o = epc_i;
        end else if (illegal_i) begin
            next_pc_o  = EXC_VECTOR;
            take_exc_o = 1'b1;
        end else if (jmp_i) begin
            next_pc_o = seq_pc_i + jmp_disp_i;
        end else if (halt_i) begin
            halt_o = 1'b1;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: one outstanding memory read, IF/ID register,
// exception PC and halt handling.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_p1,
    output logic [15:0] imem_addr_p1,
    input  logic        imem_rdy_p1,
    input  logic [15:0] imem_data_p1,
    input  logic        stall_idif_p1,
    input  logic        halt_idif_p1,
    input  logic        illegal_op_idif_p1,
    input  logic        return_execution_idif_p1,
    input  logic        jmp_displacement_idif_p1,
    input  logic [15:0] jmp_displacement_value_idif_p1,
    input  logic        redirect_ixif_p1,
    input  logic [15:0] redirect_pc_ixif_p1,
    output logic [15:0] inst_ifid_p1,
    output logic [15:0] pc_p1,
    output logic        inst_valid_ifid_p1,
    output logic [15:0] epc_p1,
    output logic        halted_p1
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pend_q, pend_d;
    logic         squash_q, squash_d;
    logic [15:0]  inst_q, inst_d;
    logic [15:0]  pcp1_q, pcp1_d;
    logic         valid_q, valid_d;
    logic [15:0]  epc_q, epc_d;

    logic [15:0]  npc;
    logic         npc_exc;
    logic         npc_halt;

    fetch_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .redirect_i    (redirect_ixif_p1),
        .redirect_pc_i (redirect_pc_ixif_p1),
        .rti_i         (return_execution_idif_p1),
        .epc_i         (epc_q),
        .illegal_i     (illegal_op_idif_p1),
        .jmp_i         (jmp_displacement_idif_p1),
        .jmp_disp_i    (jmp_displacement_value_idif_p1),
        .halt_i        (halt_idif_p1),
        .seq_pc_i      (pcp1_q),
        .next_pc_o     (npc),
        .take_exc_o    (npc_exc),
        .halt_o        (npc_halt)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            squash_q <= 1'b0;
            inst_q   <= NOP_INST;
            pcp1_q   <= '0;
            valid_q  <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            squash_q <= squash_d;
            inst_q   <= inst_d;
            pcp1_q   <= pcp1_d;
            valid_q  <= valid_d;
            epc_q    <= epc_d;
        end
    end

    // Next-state logic for the fetch/issue/halt sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        squash_d = squash_q;
        inst_d   = inst_q;
        pcp1_d   = pcp1_q;
        valid_d  = valid_q;
        epc_d    = epc_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_rdy_p1) begin
                    // A redirect in the completing cycle discards the word
                    // directly; an earlier one parked its target in pend_q.
                    if (redirect_ixif_p1) begin
                        pc_d     = redirect_pc_ixif_p1;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        pc_d     = pend_q;
                        squash_d = 1'b0;
                    end else begin
                        inst_d  = imem_data_p1;
                        pcp1_d  = pc_q + PC_STEP;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (redirect_ixif_p1) begin
                    // Address must stay stable until the memory answers.
                    pend_d   = redirect_pc_ixif_p1;
                    squash_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (redirect_ixif_p1 || !stall_idif_p1) begin
                    valid_d = 1'b0;
                    pc_d    = npc;
                    state_d = npc_halt ? ST_HALTED : ST_FETCH;
                    if (npc_exc) begin
                        epc_d = pcp1_q;
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req_p1        = (state_q == ST_FETCH);
    assign imem_addr_p1       = pc_q;
    assign inst_ifid_p1       = inst_q;
    assign pc_p1              = pcp1_q;
    assign inst_valid_ifid_p1 = valid_q;
    assign epc_p1             = epc_q;
    assign halted_p1          = (state_q == ST_HALTED);

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 16'h0002, PC loaded on illegal-op exception.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req_p1  out  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr_p1  out  16  read address, equal to current PC.
REQ-007 SHALL have port imem_rdy_p1  in  1  read-data-valid; completes the outstanding request.
REQ-008 SHALL have port imem_data_p1  in  16  instruction word, valid when imem_rdy_p1=1.
REQ-009 SHALL have port stall_idif_p1  in  1  decode/downstream cannot accept; hold IF/ID.
REQ-010 SHALL have port halt_idif_p1  in  1  decoded HALT.
REQ-011 SHALL have port illegal_op_idif_p1  in  1  decoded illegal-op exception.
REQ-012 SHALL have port return_execution_idif_p1  in  1  decoded RTI; PC <- EPC.
REQ-013 SHALL have port jmp_displacement_idif_p1  in  1  decoded J/JAL.
REQ-014 SHALL have port jmp_displacement_value_idif_p1  in  16  sign-extended displacement.
REQ-015 SHALL have port redirect_ixif_p1  in  1  execute-resolved branch/JR redirect.
REQ-016 SHALL have port redirect_pc_ixif_p1  in  16  redirect target.
REQ-017 SHALL have port inst_ifid_p1  out  16  instruction to decode.
REQ-018 SHALL have port pc_p1  out  16  PC+2 of inst_ifid_p1.
REQ-019 SHALL have port inst_valid_ifid_p1  out  1  inst_ifid_p1/pc_p1 valid.
REQ-020 SHALL have port epc_p1  out  16  exception return PC.
REQ-021 SHALL have port halted_p1  out  1  fetch permanently stopped.

Function
REQ-022 SHALL implement states FETCH, ISSUE, HALTED; one outstanding memory request maximum.
REQ-023 FETCH: imem_req_p1=1, imem_addr_p1=PC held stable until imem_rdy_p1; other states imem_req_p1=0.
REQ-024 FETCH with imem_rdy_p1=1 and no pending squash: inst_ifid_p1<=imem_data_p1, pc_p1<=PC+2 (mod 2^16), inst_valid_ifid_p1<=1, -> ISSUE next cycle.
REQ-025 redirect_ixif_p1=1 in FETCH SHALL set PC-pending=redirect_pc_ixif_p1 and squash flag; returned data discarded, PC<=pending, stay FETCH (new request next cycle); if imem_rdy_p1 same cycle, discard that data directly, no flag.
REQ-026 ISSUE with stall_idif_p1=1 SHALL hold all IF/ID outputs and PC unchanged, except redirect_ixif_p1 still applies.
REQ-027 ISSUE with stall_idif_p1=0 (or redirect) SHALL select next PC by priority: redirect -> redirect_pc_ixif_p1; return_execution -> epc_p1; illegal_op -> EXC_VECTOR with epc_p1<=pc_p1; jmp_displacement -> pc_p1+displacement (mod 2^16); halt -> state HALTED; else pc_p1.
REQ-028 Leaving ISSUE SHALL clear inst_valid_ifid_p1 and enter FETCH (or HALTED); fetch-to-issue throughput one instruction per 2+memory-latency cycles.
REQ-029 Redirect in ISSUE SHALL override halt/illegal/jump of the younger decoded instruction; epc_p1 not written.
REQ-030 HALTED: imem_req_p1=0, inst_valid_ifid_p1=0, halted_p1=1; all inputs ignored; exit only via rst.
REQ-031 epc_p1 SHALL change only on accepted illegal_op (REQ-027).

Reset
REQ-032 rst SHALL yield: state FETCH, PC=RESET_PC, inst_ifid_p1=16'h0800 (NOP), pc_p1=0, inst_valid_ifid_p1=0, epc_p1=0, halted_p1=0, squash flag=0.
REQ-033 rst mid-request SHALL abandon it; memory shares rst; first post-reset request addresses RESET_PC.

Structure
REQ-034 fetch_pkg SHALL hold state enum, RESET_PC/EXC_VECTOR defaults, NOP encoding 16'h0800.
REQ-035 Next-PC priority mux SHALL be sub-module fetch_next_pc (combinational); FSM/registers in fetch.

Verification
REQ-036 Reset, 1-cycle memory: addresses 0x0000,0x0002,0x0004 requested in order; pc_p1 0x0002,0x0004,0x0006.
REQ-037 J with displacement 16'hFFFE at PC 0x0010 -> next imem_addr_p1=0x0010.
REQ-038 Illegal op at PC 0x0020 then RTI at EXC_VECTOR -> epc_p1=0x0022, fetch 0x0002 then 0x0022.
REQ-039 redirect to 0x0100 during 3-cycle memory wait -> returned word discarded, inst_valid stays 0, next address 0x0100.
REQ-040 HALT with simultaneous redirect -> redirect wins; HALT alone -> halted_p1=1, imem_req_p1=0 forever; stall 5 cycles in ISSUE -> outputs held.
